// File: rtl/trdb_align_stream.sv
// Byte-aligning packer: turns variable-length trace packets (with an optional
// length header byte) into a gap-free little-endian stream of bus words.
module trdb_align_stream #(
    parameter int unsigned DATA_WIDTH = 32'd32,
    parameter int unsigned PACKET_LEN = 32'd256,
    parameter int unsigned HEADER_EN  = 32'd1
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [PACKET_LEN-1:0]         payload_bits_i,
    input  logic [$clog2(PACKET_LEN):0]   payload_len_i,
    input  logic                          valid_i,
    output logic                          grant_o,
    input  logic                          flush_i,
    output logic                          flush_done_o,
    output logic [DATA_WIDTH-1:0]         data_o,
    output logic                          valid_o,
    input  logic                          ready_i
);

    localparam int unsigned DATA_BYTES = DATA_WIDTH / 32'd8;
    localparam int unsigned LEN_W      = $clog2(PACKET_LEN) + 32'd1;
    localparam int unsigned N_MAX      = (PACKET_LEN + 32'd7) / 32'd8;
    localparam int unsigned L_MAX      = N_MAX + HEADER_EN;
    localparam int unsigned PTR_W      = $clog2(L_MAX + DATA_BYTES + 32'd1);
    localparam int unsigned CNT_W      = $clog2(DATA_BYTES);
    localparam int unsigned RES_W      = DATA_WIDTH - 32'd8;
    // Stream vector is at least one bus word wide so the window slice is always legal.
    localparam int unsigned SB         = (L_MAX * 32'd8 > DATA_WIDTH) ? L_MAX * 32'd8 : DATA_WIDTH;
    localparam int unsigned HDR_SHIFT  = 32'd8 - 32'd8 * HEADER_EN;

    function automatic logic [PTR_W-1:0] min_bytes(input logic [PTR_W-1:0] a,
                                                   input logic [PTR_W-1:0] b);
        return (a < b) ? a : b;
    endfunction

    logic [RES_W-1:0]      res_r;
    logic [CNT_W-1:0]      res_cnt_r;
    logic [PTR_W-1:0]      ptr_r;
    logic [DATA_WIDTH-1:0] data_r;
    logic                  valid_r;

    logic [RES_W-1:0]      res_nxt_s;
    logic [CNT_W-1:0]      res_cnt_nxt_s;
    logic [PTR_W-1:0]      ptr_nxt_s;
    logic [DATA_WIDTH-1:0] data_nxt_s;
    logic                  valid_nxt_s;

    logic [LEN_W-1:0]      len_c_s;
    logic [LEN_W:0]        n_wide_s;
    logic [PTR_W-1:0]      n_bytes_s;
    logic [PTR_W-1:0]      stream_len_s;
    logic [7:0]            hdr_byte_s;
    logic [N_MAX*8-1:0]    payload_mask_s;
    logic [N_MAX*8+7:0]    hdr_cat_s;
    logic [SB-1:0]         stream_s;
    logic [DATA_WIDTH-1:0] window_s;
    logic [DATA_WIDTH-1:0] take_mask_s;
    logic [DATA_WIDTH-1:0] res_pad_s;
    logic [DATA_WIDTH-1:0] word_s;
    logic [PTR_W-1:0]      free_s;
    logic [PTR_W-1:0]      rem_s;
    logic [PTR_W-1:0]      take_s;
    logic [PTR_W-1:0]      fill_s;
    logic                  full_s;
    logic                  last_s;
    logic                  advance_s;
    logic                  flush_qual_s;

    // Packet length clamp and derived byte counts.
    always_comb begin
        len_c_s      = (payload_len_i > LEN_W'(PACKET_LEN)) ? LEN_W'(PACKET_LEN) : payload_len_i;
        n_wide_s     = ({1'b0, len_c_s} + (LEN_W + 32'd1)'(32'd7)) >> 3;
        n_bytes_s    = PTR_W'(n_wide_s);
        hdr_byte_s   = 8'(n_wide_s);
        stream_len_s = n_bytes_s + PTR_W'(HEADER_EN);
    end

    // Zero every payload bit at or above the packet length.
    always_comb begin
        payload_mask_s = {(N_MAX * 8){1'b0}};
        for (int k = 0; k < int'(PACKET_LEN); k++) begin
            payload_mask_s[k] = payload_bits_i[k] & (k < int'(len_c_s));
        end
    end

    // Build the packet byte stream and the slice of it that fits in this word.
    always_comb begin
        hdr_cat_s   = {payload_mask_s, hdr_byte_s};
        stream_s    = SB'(hdr_cat_s >> HDR_SHIFT);
        window_s    = DATA_WIDTH'(stream_s >> {ptr_r, 3'b000});
        free_s      = PTR_W'(DATA_BYTES) - PTR_W'(res_cnt_r);
        rem_s       = stream_len_s - ptr_r;
        take_s      = min_bytes(free_s, rem_s);
        take_mask_s = ~({DATA_WIDTH{1'b1}} << {take_s, 3'b000});
        res_pad_s   = {8'h00, res_r};
        word_s      = res_pad_s | ((window_s & take_mask_s) << {res_cnt_r, 3'b000});
        fill_s      = PTR_W'(res_cnt_r) + take_s;
        full_s      = (fill_s == PTR_W'(DATA_BYTES));
        last_s      = ((ptr_r + take_s) == stream_len_s);
    end

    // Handshake qualifiers; both are suppressed while reset is asserted.
    always_comb begin
        advance_s    = !valid_r || ready_i;
        grant_o      = !rst_i && advance_s && valid_i && last_s;
        flush_qual_s = !rst_i && advance_s && !valid_i && flush_i && (ptr_r == {PTR_W{1'b0}});
        flush_done_o = flush_qual_s;
    end

    // Next-state selection for residual, pointer and output word.
    always_comb begin
        res_nxt_s     = res_r;
        res_cnt_nxt_s = res_cnt_r;
        ptr_nxt_s     = ptr_r;
        data_nxt_s    = data_r;
        valid_nxt_s   = valid_r;
        if (advance_s) begin
            if (valid_i) begin
                if (full_s) begin
                    data_nxt_s    = word_s;
                    valid_nxt_s   = 1'b1;
                    res_nxt_s     = {RES_W{1'b0}};
                    res_cnt_nxt_s = {CNT_W{1'b0}};
                end else begin
                    valid_nxt_s   = 1'b0;
                    res_nxt_s     = word_s[RES_W-1:0];
                    res_cnt_nxt_s = CNT_W'(fill_s);
                end
                if (last_s) begin
                    ptr_nxt_s = {PTR_W{1'b0}};
                end else begin
                    ptr_nxt_s = ptr_r + take_s;
                end
            end else if (flush_qual_s && (res_cnt_r != {CNT_W{1'b0}})) begin
                // Unused upper residual bytes are kept at zero, so this is already zero-filled.
                data_nxt_s    = res_pad_s;
                valid_nxt_s   = 1'b1;
                res_nxt_s     = {RES_W{1'b0}};
                res_cnt_nxt_s = {CNT_W{1'b0}};
            end else begin
                valid_nxt_s = 1'b0;
            end
        end else begin
            valid_nxt_s = valid_r;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            res_r     <= {RES_W{1'b0}};
            res_cnt_r <= {CNT_W{1'b0}};
            ptr_r     <= {PTR_W{1'b0}};
            data_r    <= {DATA_WIDTH{1'b0}};
            valid_r   <= 1'b0;
        end else begin
            res_r     <= res_nxt_s;
            res_cnt_r <= res_cnt_nxt_s;
            ptr_r     <= ptr_nxt_s;
            data_r    <= data_nxt_s;
            valid_r   <= valid_nxt_s;
        end
    end

    assign data_o  = data_r;
    assign valid_o = valid_r;

endmodule

// File: tb/tb_trdb_align_stream.sv
// Self-checking bench for trdb_align_stream: directed cases plus random packets
// scored against a byte-queue reference model of the packed stream.
module tb_trdb_align_stream;

    logic         clk = 1'b0;
    logic         rst_i;
    logic [255:0] payload_bits_i;
    logic [8:0]   payload_len_i;
    logic         valid_i, flush_i, ready_i;
    logic         grant_o, flush_done_o, valid_o;
    logic [31:0]  data_o;

    logic [255:0] bits0;
    logic [8:0]   len0;
    logic         valid0, flush0, ready0;
    logic         grant0, fdone0, vout0;
    logic [31:0]  data0;

    int n_assert = 0;
    int n_fail   = 0;

    logic [7:0]  mq[$];
    logic [31:0] ew[$];

    logic        s_grant, s_fdone, s_valid, s_grant0, s_fdone0, s_valid0;
    logic [31:0] s_data, s_data0, prev_data;
    bit          prev_hold = 1'b0;

    logic [255:0] pay;
    int           rlen, waited;
    bit           got;

    always #5 clk = ~clk;

    trdb_align_stream #(.DATA_WIDTH(32), .PACKET_LEN(256), .HEADER_EN(1)) dut (
        .clk_i(clk), .rst_i(rst_i), .payload_bits_i(payload_bits_i),
        .payload_len_i(payload_len_i), .valid_i(valid_i), .grant_o(grant_o),
        .flush_i(flush_i), .flush_done_o(flush_done_o), .data_o(data_o),
        .valid_o(valid_o), .ready_i(ready_i));

    trdb_align_stream #(.DATA_WIDTH(32), .PACKET_LEN(256), .HEADER_EN(0)) dut0 (
        .clk_i(clk), .rst_i(rst_i), .payload_bits_i(bits0),
        .payload_len_i(len0), .valid_i(valid0), .grant_o(grant0),
        .flush_i(flush0), .flush_done_o(fdone0), .data_o(data0),
        .valid_o(vout0), .ready_i(ready0));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: append the packet's stream bytes, cut complete 4-byte words.
    task automatic model_push(input int len, input logic [255:0] bits);
        int lc;
        int n;
        logic [7:0] v;
        lc = (len > 256) ? 256 : len;
        n  = (lc + 7) / 8;
        mq.push_back(8'(n));
        for (int j = 0; j < n; j++) begin
            v = 8'h00;
            for (int b = 0; b < 8; b++)
                if (8 * j + b < lc) v[b] = bits[8 * j + b];
            mq.push_back(v);
        end
        while (mq.size() >= 4) begin
            ew.push_back({mq[3], mq[2], mq[1], mq[0]});
            repeat (4) void'(mq.pop_front());
        end
    endtask

    task automatic present(input int len, input logic [255:0] bits);
        payload_len_i  = 9'(len);
        payload_bits_i = bits;
        valid_i        = 1'b1;
        model_push(len, bits);
    endtask

    // One clock: sample at the falling edge, score outputs, return just after the rising edge.
    task automatic cyc();
        logic [31:0] w;
        @(negedge clk);
        s_grant  = grant_o;  s_fdone  = flush_done_o; s_valid  = valid_o; s_data  = data_o;
        s_grant0 = grant0;   s_fdone0 = fdone0;       s_valid0 = vout0;   s_data0 = data0;
        if (prev_hold) begin
            chk("hold_valid", 64'(s_valid), 64'd1);
            chk("hold_data", 64'(s_data), 64'(prev_data));
        end
        if (s_valid === 1'b1 && ready_i === 1'b1) begin
            chk("word_expected", 64'(ew.size() != 0), 64'd1);
            if (ew.size() != 0) chk("word", 64'(s_data), 64'(ew.pop_front()));
        end
        if (s_fdone === 1'b1 && mq.size() > 0) begin
            w = 32'h0;
            for (int i = 0; i < mq.size(); i++) w[8 * i +: 8] = mq[i];
            ew.push_back(w);
            mq.delete();
        end
        prev_hold = (s_valid === 1'b1) && (ready_i === 1'b0);
        prev_data = s_data;
        if (rst_i) begin
            mq.delete();
            ew.delete();
            prev_hold = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_i = 1'b1; valid_i = 1'b1; flush_i = 1'b1; ready_i = 1'b1;
        payload_len_i = 9'd8; payload_bits_i = 256'h5;
        valid0 = 1'b0; flush0 = 1'b0; ready0 = 1'b1; len0 = 9'd0; bits0 = 256'h0;
        repeat (2) begin
            cyc();
            chk("rst_grant", 64'(s_grant), 64'd0);
            chk("rst_fdone", 64'(s_fdone), 64'd0);
            chk("rst_valid", 64'(s_valid), 64'd0);
            chk("rst_data", 64'(s_data), 64'd0);
        end
        rst_i = 1'b0; valid_i = 1'b0; flush_i = 1'b0;
        cyc();

        // Exact word
        present(24, 256'hCCBBAA);
        cyc(); chk("t1_grant", 64'(s_grant), 64'd1);
        valid_i = 1'b0;
        cyc(); chk("t1_valid", 64'(s_valid), 64'd1); chk("t1_data", 64'(s_data), 64'hCCBBAA03);

        // Merging two short packets
        present(8, 256'h11);
        cyc(); chk("t2_grant_a", 64'(s_grant), 64'd1);
        present(8, 256'h22);
        cyc(); chk("t2_grant_b", 64'(s_grant), 64'd1); chk("t2_no_out", 64'(s_valid), 64'd0);
        valid_i = 1'b0;
        cyc(); chk("t2_valid", 64'(s_valid), 64'd1); chk("t2_data", 64'(s_data), 64'h22011101);

        // Multi-word packet
        present(56, 256'h07060504030201);
        cyc(); chk("t3_grant1", 64'(s_grant), 64'd0);
        cyc(); chk("t3_grant2", 64'(s_grant), 64'd1); chk("t3_data1", 64'(s_data), 64'h03020107);
        valid_i = 1'b0;
        cyc(); chk("t3_data2", 64'(s_data), 64'h07060504);

        // Backpressure
        present(24, 256'h332211);
        cyc(); chk("t4_grant_a", 64'(s_grant), 64'd1);
        present(24, 256'h665544);
        ready_i = 1'b0;
        repeat (5) begin
            cyc();
            chk("t4_bp_grant", 64'(s_grant), 64'd0);
            chk("t4_bp_valid", 64'(s_valid), 64'd1);
            chk("t4_bp_data", 64'(s_data), 64'h33221103);
        end
        ready_i = 1'b1;
        cyc(); chk("t4_grant_b", 64'(s_grant), 64'd1); chk("t4_data_a", 64'(s_data), 64'h33221103);
        valid_i = 1'b0;
        cyc(); chk("t4_data_b", 64'(s_data), 64'h66554403);

        // Flush of a partial word, then a repeated flush
        present(8, 256'h5A);
        cyc(); chk("t5_grant", 64'(s_grant), 64'd1);
        valid_i = 1'b0; flush_i = 1'b1;
        cyc(); chk("t5_fdone1", 64'(s_fdone), 64'd1);
        cyc(); chk("t5_fdone2", 64'(s_fdone), 64'd1);
        chk("t5_valid", 64'(s_valid), 64'd1); chk("t5_data", 64'(s_data), 64'h00005A01);
        cyc(); chk("t5_fdone3", 64'(s_fdone), 64'd1); chk("t5_no_out", 64'(s_valid), 64'd0);
        flush_i = 1'b0;

        // Partial last byte and zero-length packet
        present(12, 256'hFABC);
        cyc(); chk("t6_grant12", 64'(s_grant), 64'd1);
        present(0, 256'hFFFF);
        cyc(); chk("t6_grant0", 64'(s_grant), 64'd1);
        valid_i = 1'b0;
        cyc(); chk("t6_valid", 64'(s_valid), 64'd1); chk("t6_data", 64'(s_data), 64'h000ABC02);

        // Reset in the middle of a multi-word packet, then re-present it
        present(56, 256'h07060504030201);
        cyc(); chk("t7_grant1", 64'(s_grant), 64'd0);
        rst_i = 1'b1;
        cyc(); chk("t7_rst_grant", 64'(s_grant), 64'd0);
        rst_i = 1'b0;
        present(56, 256'h07060504030201);
        cyc(); chk("t7_valid_cleared", 64'(s_valid), 64'd0); chk("t7_grant_r1", 64'(s_grant), 64'd0);
        cyc(); chk("t7_grant_r2", 64'(s_grant), 64'd1); chk("t7_data1", 64'(s_data), 64'h03020107);
        valid_i = 1'b0;
        cyc(); chk("t7_data2", 64'(s_data), 64'h07060504);

        // Header disabled instance
        valid0 = 1'b1; len0 = 9'd32; bits0 = 256'hDEADBEEF;
        cyc(); chk("h0_grant", 64'(s_grant0), 64'd1);
        len0 = 9'd0; bits0 = 256'hFF;
        cyc(); chk("h0_grant_len0", 64'(s_grant0), 64'd1);
        chk("h0_valid", 64'(s_valid0), 64'd1); chk("h0_data", 64'(s_data0), 64'hDEADBEEF);
        len0 = 9'd8; bits0 = 256'h77;
        cyc(); chk("h0_len0_no_out", 64'(s_valid0), 64'd0); chk("h0_grant77", 64'(s_grant0), 64'd1);
        valid0 = 1'b0; flush0 = 1'b1;
        cyc(); chk("h0_fdone", 64'(s_fdone0), 64'd1);
        flush0 = 1'b0;
        cyc(); chk("h0_flush_valid", 64'(s_valid0), 64'd1); chk("h0_flush_data", 64'(s_data0), 64'h77);

        // Random packets with random backpressure and occasional flushes
        for (int p = 0; p < 150; p++) begin
            rlen = $urandom_range(0, 290);
            if ($urandom_range(0, 9) == 0) rlen = 0;
            for (int i = 0; i < 8; i++) pay[32 * i +: 32] = $urandom();
            present(rlen, pay);
            waited = 0; got = 1'b0;
            while (!got && waited < 100) begin
                ready_i = ($urandom_range(0, 3) != 0);
                cyc();
                got = (s_grant === 1'b1);
                waited++;
            end
            chk("rand_grant", 64'(got), 64'd1);
            valid_i = 1'b0;
            if ($urandom_range(0, 7) == 0) begin
                flush_i = 1'b1; waited = 0; got = 1'b0;
                while (!got && waited < 20) begin
                    ready_i = ($urandom_range(0, 3) != 0);
                    cyc();
                    got = (s_fdone === 1'b1);
                    waited++;
                end
                chk("rand_flush", 64'(got), 64'd1);
                flush_i = 1'b0;
            end else if ($urandom_range(0, 3) == 0) begin
                ready_i = ($urandom_range(0, 1) != 0);
                cyc();
            end
        end

        // Drain: flush the residual and make sure every expected word came out
        ready_i = 1'b1; flush_i = 1'b1; waited = 0; got = 1'b0;
        while (!got && waited < 20) begin
            cyc();
            got = (s_fdone === 1'b1);
            waited++;
        end
        chk("final_flush", 64'(got), 64'd1);
        flush_i = 1'b0;
        repeat (4) cyc();
        chk("final_words_left", 64'(ew.size()), 64'd0);
        chk("final_bytes_left", 64'(mq.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
